// File: rtl/soc_system_audio_status_pio.sv
// Avalon-MM input PIO: synchronised status bus with per-bit edge capture,
// a saturating event counter and a maskable level interrupt.
module soc_system_audio_status_pio #(
   parameter int WIDTH       = 16,
   parameter int SYNC_STAGES = 2,
   parameter int EDGE_TYPE   = 0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   input  logic [WIDTH-1:0] in_port,
   output logic             irq
);

   logic [WIDTH-1:0] sync_q [SYNC_STAGES];
   logic [WIDTH-1:0] data_s;
   logic [WIDTH-1:0] prev_q;
   logic [WIDTH-1:0] rise;
   logic [WIDTH-1:0] fall;
   logic [WIDTH-1:0] det;
   logic [WIDTH-1:0] clr;
   logic [WIDTH-1:0] edgecap_q, edgecap_d;
   logic [WIDTH-1:0] irqmask_q, irqmask_d;
   logic [15:0]      evcount_q, evcount_d;
   logic [31:0]      readdata_q, readdata_d;
   logic             irq_q, irq_d;
   logic             wr_en;
   logic             unused_wdata;

   assign wr_en        = chipselect & write;
   assign data_s       = sync_q[SYNC_STAGES-1];
   assign rise         = data_s & ~prev_q;
   assign fall         = ~data_s & prev_q;
   assign unused_wdata = ^writedata;

   always_comb begin
      det = rise | fall;
      if (EDGE_TYPE == 0)
         det = rise;
      else if (EDGE_TYPE == 1)
         det = fall;
   end

   assign clr = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

   // A fresh edge on a bit beats a W1C to that bit in the same cycle.
   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_bit
         assign edgecap_d[gi] = det[gi] | (edgecap_q[gi] & ~clr[gi]);
      end
   endgenerate

   assign irqmask_d = (wr_en && address == 2'd2) ? writedata[WIDTH-1:0] : irqmask_q;
   assign irq_d     = |(edgecap_q & irqmask_q);

   // One count per cycle with any edge; a clear write wins over an increment.
   always_comb begin
      evcount_d = evcount_q;
      if (wr_en && address == 2'd1)
         evcount_d = '0;
      else if ((|det) && evcount_q != 16'hFFFF)
         evcount_d = evcount_q + 16'd1;
   end

   always_comb begin
      readdata_d = '0;
      case (address)
         2'd0:    readdata_d[WIDTH-1:0] = data_s;
         2'd1:    readdata_d[15:0]      = evcount_q;
         2'd2:    readdata_d[WIDTH-1:0] = irqmask_q;
         default: readdata_d[WIDTH-1:0] = edgecap_q;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int k = 0; k < SYNC_STAGES; k++)
            sync_q[k] <= '0;
      end else begin
         sync_q[0] <= in_port;
         for (int k = 1; k < SYNC_STAGES; k++)
            sync_q[k] <= sync_q[k-1];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         prev_q     <= '0;
         edgecap_q  <= '0;
         irqmask_q  <= '0;
         evcount_q  <= '0;
         readdata_q <= '0;
         irq_q      <= 1'b0;
      end else begin
         prev_q     <= data_s;
         edgecap_q  <= edgecap_d;
         irqmask_q  <= irqmask_d;
         evcount_q  <= evcount_d;
         readdata_q <= readdata_d;
         irq_q      <= irq_d;
      end
   end

   assign readdata = readdata_q;
   assign irq      = irq_q;

endmodule

// File: tb/tb_soc_system_audio_status_pio.sv
// Bench for soc_system_audio_status_pio: three parameterisations on a shared bus,
// directed sequences plus random traffic checked every cycle against a reference model.
module tb_soc_system_audio_status_pio;

   logic        clk;
   logic        reset_n;
   logic [1:0]  address;
   logic        chipselect;
   logic        write;
   logic [31:0] writedata;
   logic [15:0] in_port;
   logic [31:0] rd0, rd1, rd2;
   logic        irq0, irq1, irq2;
   bit          toggle_en;

   int n_tests;
   int n_fail;

   soc_system_audio_status_pio #(.WIDTH(16), .SYNC_STAGES(2), .EDGE_TYPE(0)) u_dut0 (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write(write), .writedata(writedata), .readdata(rd0), .in_port(in_port), .irq(irq0));

   soc_system_audio_status_pio #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(2)) u_dut1 (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write(write), .writedata(writedata), .readdata(rd1), .in_port(in_port[7:0]), .irq(irq1));

   soc_system_audio_status_pio #(.WIDTH(12), .SYNC_STAGES(3), .EDGE_TYPE(1)) u_dut2 (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write(write), .writedata(writedata), .readdata(rd2), .in_port(in_port[11:0]), .irq(irq2));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Instance parameters as seen by the model.
   function automatic int pw(input int i);
      case (i)
         0:       return 16;
         1:       return 8;
         default: return 12;
      endcase
   endfunction

   function automatic int ps(input int i);
      return (i == 2) ? 3 : 2;
   endfunction

   function automatic int pe(input int i);
      case (i)
         0:       return 0;
         1:       return 2;
         default: return 1;
      endcase
   endfunction

   // Reference state: a delay line of sampled inputs stands in for the synchroniser.
   logic [31:0] m_line [3][4];
   logic [31:0] m_prev [3];
   logic [31:0] m_ecap [3];
   logic [31:0] m_mask [3];
   logic [31:0] m_rd   [3];
   logic        m_irq  [3];
   int          m_ev   [3];

   function automatic void model_reset();
      for (int i = 0; i < 3; i++) begin
         for (int k = 0; k < 4; k++)
            m_line[i][k] = '0;
         m_prev[i] = '0;
         m_ecap[i] = '0;
         m_mask[i] = '0;
         m_rd[i]   = '0;
         m_irq[i]  = 1'b0;
         m_ev[i]   = 0;
      end
   endfunction

   function automatic void model_edge();
      logic [31:0] msk, ds, rise, fall, det, clr;
      bit we;
      if (!reset_n) begin
         model_reset();
         return;
      end
      we = chipselect && write;
      for (int i = 0; i < 3; i++) begin
         msk  = (32'd1 << pw(i)) - 32'd1;
         ds   = m_line[i][ps(i)-1];
         rise = ds & ~m_prev[i];
         fall = ~ds & m_prev[i] & msk;
         det  = (pe(i) == 0) ? rise : (pe(i) == 1) ? fall : (rise | fall);
         case (address)
            2'd0:    m_rd[i] = ds;
            2'd1:    m_rd[i] = 32'(m_ev[i]);
            2'd2:    m_rd[i] = m_mask[i];
            default: m_rd[i] = m_ecap[i];
         endcase
         m_irq[i]  = |(m_ecap[i] & m_mask[i]);
         clr       = (we && address == 2'd3) ? (writedata & msk) : 32'd0;
         m_ecap[i] = det | (m_ecap[i] & ~clr);
         if (we && address == 2'd1)
            m_ev[i] = 0;
         else if (det != 0)
            m_ev[i] = (m_ev[i] >= 65535) ? 65535 : m_ev[i] + 1;
         if (we && address == 2'd2)
            m_mask[i] = writedata & msk;
         m_prev[i] = ds;
         for (int k = 3; k > 0; k--)
            m_line[i][k] = m_line[i][k-1];
         m_line[i][0] = {16'h0, in_port} & msk;
      end
   endfunction

   function automatic void chk(input string name, input logic [31:0] got,
                               input logic [31:0] exp, input bit verbose);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         if (n_fail <= 40)
            $display("FAIL %s got=%h expected=%h", name, got, exp);
      end else if (verbose) begin
         $display("[TB] %s = %h ok", name, got);
      end
   endfunction

   function automatic void compare_all();
      chk("model_rd0", rd0, m_rd[0], 1'b0);
      chk("model_rd1", rd1, m_rd[1], 1'b0);
      chk("model_rd2", rd2, m_rd[2], 1'b0);
      chk("model_irq0", {31'b0, irq0}, {31'b0, m_irq[0]}, 1'b0);
      chk("model_irq1", {31'b0, irq1}, {31'b0, m_irq[1]}, 1'b0);
      chk("model_irq2", {31'b0, irq2}, {31'b0, m_irq[2]}, 1'b0);
   endfunction

   task automatic cycle();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      compare_all();
      if (toggle_en)
         in_port = in_port ^ 16'h0001;
   endtask

   task automatic idle(input int n);
      repeat (n) cycle();
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      address    = a;
      chipselect = 1'b1;
      write      = 1'b1;
      writedata  = d;
      cycle();
      chipselect = 1'b0;
      write      = 1'b0;
   endtask

   task automatic rd(input logic [1:0] a);
      address    = a;
      chipselect = 1'b0;
      write      = 1'b0;
      cycle();
   endtask

   task automatic quiesce(input logic [15:0] val);
      in_port = val;
      idle(5);
      wr(2'd3, 32'hFFFF_FFFF);
      wr(2'd1, 32'h0);
      wr(2'd2, 32'h0);
   endtask

   typedef struct {
      logic [1:0]  addr;
      logic [31:0] wdata;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs [8];

   initial begin
      vecs[0] = '{2'd3, 32'h0000_00F0, 32'h0000_FF0F};
      vecs[1] = '{2'd3, 32'hFFFF_0000, 32'h0000_FF0F};
      vecs[2] = '{2'd1, 32'h0000_0000, 32'h0000_0000};
      vecs[3] = '{2'd0, 32'h0000_1234, 32'h0000_FFFF};
      vecs[4] = '{2'd2, 32'hFFFF_FFFF, 32'h0000_FFFF};
      vecs[5] = '{2'd2, 32'h0000_00A5, 32'h0000_00A5};
      vecs[6] = '{2'd3, 32'hFFFF_FFFF, 32'h0000_0000};
      vecs[7] = '{2'd2, 32'h0000_0000, 32'h0000_0000};

      n_tests    = 0;
      n_fail     = 0;
      toggle_en  = 1'b0;
      reset_n    = 1'b0;
      address    = 2'd0;
      chipselect = 1'b0;
      write      = 1'b0;
      writedata  = 32'h0;
      in_port    = 16'hFFFF;
      model_reset();

      // Reset held with inputs high, then synchroniser latency on release.
      idle(3);
      chk("reset_rd0", rd0, 32'h0, 1'b1);
      chk("reset_irq0", {31'b0, irq0}, 32'h0, 1'b1);
      chk("reset_rd2", rd2, 32'h0, 1'b1);
      reset_n = 1'b1;
      idle(2);
      chk("data_lat_early", rd0, 32'h0, 1'b1);
      cycle();
      chk("data_lat_rd0", rd0, 32'h0000_FFFF, 1'b1);
      chk("data_lat_rd1", rd1, 32'h0000_00FF, 1'b1);
      cycle();
      chk("data_lat_rd2", rd2, 32'h0000_0FFF, 1'b1);

      // Register write/readback table.
      for (int v = 0; v < 8; v++) begin
         wr(vecs[v].addr, vecs[v].wdata);
         rd(vecs[v].addr);
         chk($sformatf("vec%0d", v), rd0, vecs[v].exp, 1'b1);
      end

      // Rising capture on bit 3, falling edge ignored.
      quiesce(16'h0000);
      in_port = 16'h0008;
      idle(4);
      rd(2'd3);
      chk("rise_cap", rd0, 32'h8, 1'b1);
      rd(2'd1);
      chk("rise_cnt", rd0, 32'h1, 1'b1);
      in_port = 16'h0000;
      idle(4);
      rd(2'd3);
      chk("fall_ignored_cap", rd0, 32'h8, 1'b1);
      rd(2'd1);
      chk("fall_ignored_cnt", rd0, 32'h1, 1'b1);

      // Interrupt latency and clear.
      quiesce(16'h0000);
      wr(2'd2, 32'h8);
      in_port = 16'h0008;
      idle(3);
      chk("irq_not_yet", {31'b0, irq0}, 32'h0, 1'b1);
      cycle();
      chk("irq_set", {31'b0, irq0}, 32'h1, 1'b1);
      wr(2'd3, 32'h8);
      chk("irq_hold", {31'b0, irq0}, 32'h1, 1'b1);
      cycle();
      chk("irq_clear", {31'b0, irq0}, 32'h0, 1'b1);

      // W1C landing on the same edge as a new detection.
      quiesce(16'h0000);
      in_port = 16'h0008;
      idle(2);
      wr(2'd3, 32'h8);
      rd(2'd3);
      chk("w1c_race", rd0, 32'h8, 1'b1);
      wr(2'd3, 32'h8);
      rd(2'd3);
      chk("w1c_clear", rd0, 32'h0, 1'b1);

      // Any-edge and falling instances on 0x00 -> 0xFF -> 0x00.
      quiesce(16'h0000);
      in_port = 16'h00FF;
      idle(4);
      rd(2'd0);
      chk("any_data", rd1, 32'h0000_00FF, 1'b1);
      chk("any_upper", {8'h0, rd1[31:8]}, 32'h0, 1'b1);
      in_port = 16'h0000;
      idle(4);
      rd(2'd3);
      chk("any_cap", rd1, 32'h0000_00FF, 1'b1);
      chk("fall_cap", rd2, 32'h0000_00FF, 1'b1);
      rd(2'd1);
      chk("any_cnt", rd1, 32'h2, 1'b1);
      chk("rise_once_cnt", rd0, 32'h1, 1'b1);
      chk("fall_once_cnt", rd2, 32'h1, 1'b1);

      // Counter saturation and clear-beats-increment.
      quiesce(16'h0000);
      toggle_en = 1'b1;
      idle(65550);
      rd(2'd1);
      chk("sat", rd1, 32'h0000_FFFF, 1'b1);
      idle(10);
      rd(2'd1);
      chk("sat_hold", rd1, 32'h0000_FFFF, 1'b1);
      wr(2'd1, 32'h0);
      rd(2'd1);
      chk("clr_wins", rd1, 32'h0, 1'b1);
      toggle_en = 1'b0;

      // Random traffic with a mid-run reset, checked by the model every cycle.
      for (int c = 0; c < 3000; c++) begin
         address    = 2'($urandom_range(0, 3));
         chipselect = ($urandom_range(0, 3) == 0);
         write      = 1'($urandom_range(0, 1));
         writedata  = $urandom;
         if ($urandom_range(0, 2) == 0)
            in_port = in_port ^ 16'($urandom & $urandom);
         if (c == 1500)
            reset_n = 1'b0;
         if (c == 1504)
            reset_n = 1'b1;
         cycle();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
